im_data_tx: RTL and testbench
=============================

// Module: im_data_tx
// PURPOSE
//  Transmit end of the 6-bit imager data link: serializes 24-bit pixel words (three 8-bit ADC samples)
//  into 6-bit beats on im_data/im_data_val, framed into fixed-length frames with an inter-frame gap.
//  Drives the same pins the capture path loads into its 6->24 FIFO. Used as a sensor-side emulator and link exerciser.
//  Optional internal test-pattern source replaces upstream data.
// PARAMETERS
//  WORDS_PER_FRAME  16384  24-bit words per frame (>=1)
//  GAP_CYCLES       16     idle cycles after each frame, im_data_val=0 (>=1)
//  CNT_W            16     width of word_cnt (2**CNT_W > WORDS_PER_FRAME)
// PORTS
//  clk          in   1      single clock; all logic on posedge
//  rst_n        in   1      reset, synchronous, active-low
//  en           in   1      run frames while high
//  test_mode    in   1      1 = internal pattern source, 0 = s_data stream
//  s_data       in   24     upstream pixel word, [23:16]=ADC3, [15:8]=ADC2, [7:0]=ADC1
//  s_valid      in   1      s_data valid
//  s_ready      out  1      word accepted on a cycle with s_valid & s_ready (combinational from state)
//  im_data      out  6      serialized beat, registered
//  im_data_val  out  1      beat valid, registered
//  frame_active out  1      high from frame start through end of GAP
//  frame_done   out  1      1-cycle pulse on the cycle after the last beat of a frame
//  word_cnt     out  CNT_W  words accepted in current frame
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; im_data=0, im_data_val=0, frame_active=0, frame_done=0, word_cnt=0;
//   pattern regs P1=8'h88, P2=8'h20, P3=8'h80. Mid-frame reset aborts at once; no partial word is completed.
//  States: IDLE, FETCH, SHIFT (beat 0..3), GAP.
//  IDLE: en=1 -> FETCH; latch test_mode into tm_q (held for whole frame); word_cnt<=0; frame_active<=1.
//  FETCH: s_ready = ~tm_q. Load on s_valid (tm_q=0) or unconditionally (tm_q=1) -> SHIFT beat 0.
//   tm_q=1 loads {P3,P2,P1}, then P1+=1, P2+=5, P3+=10 (mod 256). word_cnt increments on each load.
//  SHIFT: load at edge N -> beats on cycles N+1..N+4, MSB first: s[23:18], s[17:12], s[11:6], s[5:0];
//   im_data_val=1 on each beat.
//   Beat 3: s_ready=~tm_q if word_cnt<WORDS_PER_FRAME, else 0. Load here -> next word's beat 0 follows seamlessly
//   (100% duty). No load and frame not done -> FETCH, im_data_val=0 for >=1 cycle (underrun).
//   While im_data_val=0, im_data holds its last value.
//  Frame end: after beat 3 of word WORDS_PER_FRAME -> GAP; frame_done=1 for that one cycle.
//   GAP lasts exactly GAP_CYCLES cycles with im_data_val=0.
//  GAP exit: en=1 -> FETCH (new frame: re-latch tm_q, word_cnt<=0); en=0 -> IDLE, frame_active<=0.
//  en falling mid-frame: frame completes fully; no truncation. test_mode changes mid-frame are ignored.
//  s_ready is never high in IDLE or GAP, or while rst_n=0. Pattern regs persist across frames (reset only by rst_n).
//  WORDS_PER_FRAME=1: one load per frame; beat 3 never asserts s_ready.
// TESTING
//  T1: rst_n=0 2 cycles, en=1, s_valid=0 -> all outputs 0, s_ready=0 during reset, then FETCH with s_ready=1.
//  T2: one word 24'hFC0FC3 -> beats 6'h3F, 6'h00, 6'h3F, 6'h03 on cycles N+1..N+4, val=1 only on those 4 cycles.
//  T3: WORDS_PER_FRAME=4, s_valid held 1 -> 16 contiguous val beats, frame_done on cycle 17,
//   exactly GAP_CYCLES val=0 cycles, next frame restarts with word_cnt=1.
//  T4: test_mode=1 -> word0 beats from 24'h802088, word1 = 24'h8A2589; val contiguous; s_ready stays 0.
//  T5: s_valid dropped 3 cycles mid-frame -> val gap of >=3 cycles, no duplicated/lost beats, word_cnt exact.
//  T6: rst_n=0 during beat 2 -> next cycle val=0, word_cnt=0, state IDLE; en=1 restarts a clean frame.
//   en=0 mid-frame -> frame finishes, then IDLE, frame_active=0.

Source files
------------

// File: rtl/im_data_tx.sv
// im_data_tx: transmit end of the 6-bit imager data link.
//
// Serializes 24-bit pixel words (three 8-bit ADC samples) into four 6-bit
// beats, MSB first, on im_data/im_data_val. Words are grouped into frames of
// WORDS_PER_FRAME words, and each frame is followed by GAP_CYCLES idle cycles.
// When test_mode is latched high at frame start, an internal incrementing
// pattern replaces the upstream s_data stream for the whole frame.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   en           run frames while high (checked only at frame boundaries)
//   test_mode    1 = internal pattern source, 0 = s_data stream
//   s_data       upstream word, [23:16]=ADC3, [15:8]=ADC2, [7:0]=ADC1
//   s_valid      s_data valid
//   s_ready      word accepted when s_valid & s_ready (combinational)
//   im_data      serialized beat (registered, holds while im_data_val=0)
//   im_data_val  beat valid (registered)
//   frame_active high from frame start through the end of the gap
//   frame_done   one-cycle pulse on the cycle after the last beat of a frame
//   word_cnt     words loaded in the current frame
module im_data_tx #(
    parameter int unsigned WORDS_PER_FRAME = 16384,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             test_mode,
    input  logic [23:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [5:0]       im_data,
    output logic             im_data_val,
    output logic             frame_active,
    output logic             frame_done,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        GAP
    } state_t;

    localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] WPF      = CNT_W'(WORDS_PER_FRAME);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [23:0]        shreg_q, shreg_d;
    logic               tm_q, tm_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [CNT_W-1:0]   wc_d;
    logic [5:0]         im_data_d;
    logic               val_d, fd_d, fa_d;
    logic               ready, do_load, frame_full;
    logic [23:0]        load_word;

    assign frame_full = (word_cnt >= WPF);
    assign load_word  = tm_q ? {p3_q, p2_q, p1_q} : s_data;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        shreg_d   = shreg_q;
        tm_d      = tm_q;
        gap_d     = gap_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        p3_d      = p3_q;
        wc_d      = word_cnt;
        im_data_d = im_data;
        val_d     = 1'b0;
        fd_d      = 1'b0;
        fa_d      = frame_active;
        ready     = 1'b0;
        do_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH;
                    tm_d    = test_mode;
                    wc_d    = '0;
                    fa_d    = 1'b1;
                end
            end
            FETCH: begin
                ready   = ~tm_q;
                do_load = tm_q | s_valid;
            end
            SHIFT: begin
                if (beat_q != 2'd3) begin
                    // shreg always presents the next beat in [17:12]
                    beat_d    = beat_q + 2'd1;
                    im_data_d = shreg_q[17:12];
                    shreg_d   = {shreg_q[17:0], 6'd0};
                    val_d     = 1'b1;
                end else if (!frame_full) begin
                    // loading on beat 3 keeps the beat stream gapless
                    ready   = ~tm_q;
                    do_load = tm_q | s_valid;
                    if (!do_load) begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = GAP;
                    gap_d   = '0;
                    fd_d    = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (en) begin
                        state_d = FETCH;
                        tm_d    = test_mode;
                        wc_d    = '0;
                    end else begin
                        state_d = IDLE;
                        fa_d    = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            state_d   = SHIFT;
            beat_d    = 2'd0;
            shreg_d   = load_word;
            im_data_d = load_word[23:18];
            val_d     = 1'b1;
            wc_d      = word_cnt + CNT_W'(1);
            if (tm_q) begin
                p1_d = p1_q + 8'd1;
                p2_d = p2_q + 8'd5;
                p3_d = p3_q + 8'd10;
            end
        end

        s_ready = ready & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            shreg_q      <= '0;
            tm_q         <= 1'b0;
            gap_q        <= '0;
            p1_q         <= 8'h88;
            p2_q         <= 8'h20;
            p3_q         <= 8'h80;
            word_cnt     <= '0;
            im_data      <= '0;
            im_data_val  <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            shreg_q      <= shreg_d;
            tm_q         <= tm_d;
            gap_q        <= gap_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            p3_q         <= p3_d;
            word_cnt     <= wc_d;
            im_data      <= im_data_d;
            im_data_val  <= val_d;
            frame_active <= fa_d;
            frame_done   <= fd_d;
        end
    end

endmodule

// File: tb/tb_im_data_tx.sv
// Self-checking bench for im_data_tx: vector table, directed multi-cycle
// sequences, and randomized traffic checked by a stream-level reference model.
module tb_im_data_tx;

    localparam int WPF = 4;
    localparam int GAP = 3;
    localparam int N   = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, test_mode = 1'b0, s_valid = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_ready, im_data_val, frame_active, frame_done;
    logic [5:0]  im_data;
    logic [3:0]  word_cnt;
    logic        s_ready1, val1, fa1, fd1;
    logic [5:0]  im_data1;
    logic [1:0]  wc1;

    always #5 clk = ~clk;

    im_data_tx #(.WORDS_PER_FRAME(WPF), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .test_mode(test_mode),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .im_data(im_data), .im_data_val(im_data_val),
        .frame_active(frame_active), .frame_done(frame_done), .word_cnt(word_cnt)
    );

    // Single-word frames share the stimulus
    im_data_tx #(.WORDS_PER_FRAME(1), .GAP_CYCLES(GAP), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .test_mode(test_mode),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .im_data(im_data1), .im_data_val(val1),
        .frame_active(fa1), .frame_done(fd1), .word_cnt(wc1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] slice(input logic [23:0] w, input int b);
        logic [23:0] t;
        t = w >> (18 - 6 * b);
        return t[5:0];
    endfunction

    // k-th pattern word since reset: ADC1 from 0x88 step 1, ADC2 from 0x20 step 5, ADC3 from 0x80 step 10
    function automatic logic [23:0] pat(input int k);
        logic [7:0] a1, a2, a3;
        a1 = 8'(136 + k);
        a2 = 8'(32 + 5 * k);
        a3 = 8'(128 + 10 * k);
        return {a3, a2, a1};
    endfunction

    // Reference model: expected beat stream and frame bookkeeping
    logic [5:0] exp_q[$];
    int         nbeats = 0;
    int         pidx = 0;
    logic [5:0] last = '0;
    logic       tm_phase = 1'b0;
    int         nfd = 0;

    task automatic monitor();
        logic fd_exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                nbeats = 0;
                pidx   = 0;
                last   = '0;
            end else begin
                fd_exp = (nbeats == 4 * WPF);
                chk("frame_done", frame_done, fd_exp);
                if (fd_exp) begin
                    chk("val_after_last_beat", im_data_val, 0);
                    chk("ready_after_last_beat", s_ready, 0);
                    nbeats = 0;
                    nfd++;
                end
                if (tm_phase) chk("ready_in_test_mode", s_ready, 0);
                if (im_data_val) begin
                    if (tm_phase && exp_q.size() == 0) begin
                        for (int b = 0; b < 4; b++) exp_q.push_back(slice(pat(pidx), b));
                        pidx++;
                    end
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("beat_value", im_data, exp_q.pop_front());
                    if (nbeats % 4 == 0) chk("word_cnt", word_cnt, nbeats / 4 + 1);
                    nbeats++;
                    last = im_data;
                end else begin
                    chk("hold_when_idle", im_data, last);
                end
                if (!tm_phase && s_valid && s_ready)
                    for (int b = 0; b < 4; b++) exp_q.push_back(slice(s_data, b));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic tm);
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; test_mode = tm; tm_phase = tm;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic       va[N], fda[N], faa[N], rda[N];
    logic [5:0] da[N];
    logic [3:0] wca[N];

    // Records N cycles; s_valid low in [v_lo,v_hi], en low from en_off, test_mode inverted in [t_lo,t_hi]
    task automatic record(input int v_lo, input int v_hi, input int en_off, input int t_lo, input int t_hi);
        int acc1 = 0;
        int bad1 = 0;
        for (int c = 0; c < N; c++) begin
            s_data    = $urandom;
            s_valid   = !(c >= v_lo && c <= v_hi);
            en        = (c < en_off);
            test_mode = tm_phase ^ (c >= t_lo && c <= t_hi);
            @(negedge clk);
            va[c] = im_data_val; da[c] = im_data; fda[c] = frame_done;
            faa[c] = frame_active; wca[c] = word_cnt; rda[c] = s_ready;
            if (fd1) begin
                chk("wpf1_beats_per_frame", acc1, 4);
                acc1 = 0;
            end
            if (val1) acc1++;
            if (val1 && s_ready1) bad1++;
            step();
        end
        chk("wpf1_ready_during_beats", bad1, 0);
    endtask

    function automatic int first_val();
        for (int c = 0; c < N; c++) if (va[c]) return c;
        return -1;
    endfunction

    function automatic int run_len(input int from, input logic v);
        int n = 0;
        while (from + n < N && va[from + n] == v) n++;
        return n;
    endfunction

    typedef struct {
        logic rst_n, en, tm, v;
        logic [23:0] d;
        logic rdy;
        logic [5:0] q;
        logic qv, fd, fa;
        logic [3:0] wc;
    } vec_t;

    vec_t tbl[15];
    int i0, n1, z, cnt;

    initial begin
        fork
            monitor();
        join_none

        //          rst en tm v  s_data        rdy  im_data val fd fa wc
        tbl[0]  = '{0, 1, 0, 0, 24'h000000, 0, 6'h00, 0, 0, 0, 4'd0};
        tbl[1]  = '{0, 1, 0, 0, 24'h000000, 0, 6'h00, 0, 0, 0, 4'd0};
        tbl[2]  = '{1, 1, 0, 0, 24'h000000, 0, 6'h00, 0, 0, 1, 4'd0};
        tbl[3]  = '{1, 1, 0, 1, 24'hFC0FC3, 1, 6'h3F, 1, 0, 1, 4'd1};
        tbl[4]  = '{1, 1, 0, 0, 24'h000000, 0, 6'h00, 1, 0, 1, 4'd1};
        tbl[5]  = '{1, 1, 0, 0, 24'h000000, 0, 6'h3F, 1, 0, 1, 4'd1};
        tbl[6]  = '{1, 1, 0, 0, 24'h000000, 0, 6'h03, 1, 0, 1, 4'd1};
        tbl[7]  = '{1, 1, 0, 0, 24'h000000, 1, 6'h03, 0, 0, 1, 4'd1};
        tbl[8]  = '{1, 1, 0, 0, 24'h000000, 1, 6'h03, 0, 0, 1, 4'd1};
        tbl[9]  = '{1, 1, 0, 1, 24'h123456, 1, 6'h04, 1, 0, 1, 4'd2};
        tbl[10] = '{1, 1, 0, 0, 24'h000000, 0, 6'h23, 1, 0, 1, 4'd2};
        tbl[11] = '{1, 1, 0, 0, 24'h000000, 0, 6'h11, 1, 0, 1, 4'd2};
        tbl[12] = '{0, 1, 0, 1, 24'h000000, 0, 6'h00, 0, 0, 0, 4'd0};
        tbl[13] = '{1, 1, 0, 0, 24'h000000, 0, 6'h00, 0, 0, 1, 4'd0};
        tbl[14] = '{1, 1, 0, 1, 24'hABCDEF, 1, 6'h2A, 1, 0, 1, 4'd1};

        step();
        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en; test_mode = tbl[i].tm;
            s_valid = tbl[i].v; s_data = tbl[i].d;
            @(negedge clk);
            chk($sformatf("row%0d_s_ready", i), s_ready, tbl[i].rdy);
            step();
            chk($sformatf("row%0d_im_data", i), im_data, tbl[i].q);
            chk($sformatf("row%0d_val", i), im_data_val, tbl[i].qv);
            chk($sformatf("row%0d_frame_done", i), frame_done, tbl[i].fd);
            chk($sformatf("row%0d_frame_active", i), frame_active, tbl[i].fa);
            chk($sformatf("row%0d_word_cnt", i), word_cnt, tbl[i].wc);
        end

        // Full frame, s_valid held: 16 beats, done pulse, gap then one fetch cycle, restart
        do_reset(1'b0);
        record(-1, -1, 1000, -1, -1);
        i0 = first_val();
        chk("t3_started", i0 >= 0, 1);
        if (i0 >= 0 && i0 + 16 < N) begin
            chk("t3_contiguous_beats", run_len(i0, 1'b1), 16);
            chk("t3_done_pulse", fda[i0 + 16], 1);
            z = run_len(i0 + 16, 1'b0);
            chk("t3_idle_between_frames", z, GAP + 1);
            if (i0 + 16 + z < N) chk("t3_restart_word_cnt", wca[i0 + 16 + z], 1);
        end

        // Test pattern: first two words fixed by reset values; test_mode toggling mid-frame ignored
        do_reset(1'b1);
        record(-1, -1, 1000, 3, 8);
        i0 = first_val();
        chk("t4_started", i0 >= 0, 1);
        if (i0 >= 0 && i0 + 8 < N) begin
            for (int b = 0; b < 8; b++) begin
                chk($sformatf("t4_val%0d", b), va[i0 + b], 1);
                chk($sformatf("t4_beat%0d", b), da[i0 + b],
                    slice((b < 4) ? 24'h802088 : 24'h8A2589, b % 4));
            end
        end
        cnt = 0;
        for (int c = 0; c < N; c++) if (rda[c]) cnt++;
        chk("t4_ready_never_high", cnt, 0);

        // Upstream stall across a word boundary
        do_reset(1'b0);
        record(5, 7, 1000, -1, -1);
        i0 = first_val();
        chk("t5_started", i0 >= 0, 1);
        if (i0 >= 0) begin
            n1 = run_len(i0, 1'b1);
            chk("t5_first_word", n1, 4);
            z = run_len(i0 + n1, 1'b0);
            chk("t5_underrun_len", z, 3);
            cnt = run_len(i0 + n1 + z, 1'b1);
            chk("t5_rest_of_frame", cnt, 12);
            if (i0 + n1 + z + cnt < N) begin
                chk("t5_done_pulse", fda[i0 + n1 + z + cnt], 1);
                chk("t5_final_word_cnt", wca[i0 + n1 + z + cnt - 1], 4);
            end
        end

        // en dropped mid-frame: frame completes, then idle with frame_active low
        do_reset(1'b0);
        record(-1, -1, 3, -1, -1);
        i0 = first_val();
        chk("t6_started", i0 >= 0, 1);
        if (i0 >= 0 && i0 + 16 + GAP < N) begin
            chk("t6_full_frame", run_len(i0, 1'b1), 16);
            chk("t6_active_through_gap", faa[i0 + 16 + GAP - 1], 1);
            chk("t6_inactive_after_gap", faa[i0 + 16 + GAP], 0);
            cnt = 0;
            for (int c = i0 + 16; c < N; c++) if (va[c]) cnt++;
            chk("t6_no_new_frame", cnt, 0);
        end

        // Random traffic against the stream model
        nfd = 0;
        for (int r = 0; r < 4; r++) begin
            do_reset(1'($urandom_range(0, 1)));
            for (int c = 0; c < 400; c++) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = $urandom;
                en      = ($urandom_range(0, 15) != 0);
                step();
            end
        end
        chk("rand_frames_seen", nfd > 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
